// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: signal bundle between fetch/datapath and the LEGv8 control pipeline
interface pipe_ctrl_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_ext;
    logic        alu_n;
    logic        alu_z;
    logic        alu_v;
    logic        alu_c;
    logic        cbz_zero;
    logic        pc_hold;
    logic        take_branch;
    logic        br_reg;
    logic        id_reg2_rd;
    logic [1:0]  ex_alu_src;
    logic [2:0]  ex_alu_op;
    logic        ex_set_flags;
    logic        mem_read;
    logic        mem_write;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic        wb_link;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        flag_c;

    modport master (
        output instr, instr_valid, stall_ext, alu_n, alu_z, alu_v, alu_c, cbz_zero,
        input  pc_hold, take_branch, br_reg, id_reg2_rd, ex_alu_src, ex_alu_op, ex_set_flags,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link,
               flag_n, flag_z, flag_v, flag_c
    );

    modport slave (
        input  instr, instr_valid, stall_ext, alu_n, alu_z, alu_v, alu_c, cbz_zero,
        output pc_hold, take_branch, br_reg, id_reg2_rd, ex_alu_src, ex_alu_op, ex_set_flags,
               mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link,
               flag_n, flag_z, flag_v, flag_c
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: 5-stage LEGv8 control pipeline with load-use/flag hazards, freeze, squash and NZVC file
module pipe_ctrl_unit #(
    parameter logic DELAY_SLOT   = 1'b1,
    parameter logic FLAG_FWD     = 1'b1,
    parameter logic LOAD_USE_DET = 1'b1
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        OP_NOP, OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR,
        OP_B, OP_BL, OP_BLT, OP_CBZ, OP_BR
    } op_e;

    function automatic op_e decode(input logic [31:0] w);
        return w[31:22] == 10'b1001000100                     ? OP_ADDI :
               w[31:21] == 11'b10101011000                    ? OP_ADDS :
               w[31:21] == 11'b11101011000                    ? OP_SUBS :
               w[31:21] == 11'b11111000010                    ? OP_LDUR :
               w[31:21] == 11'b11111000000                    ? OP_STUR :
               w[31:26] == 6'b000101                          ? OP_B    :
               w[31:26] == 6'b100101                          ? OP_BL   :
               w[31:24] == 8'b01010100 && w[4:0] == 5'b01011  ? OP_BLT  :
               w[31:24] == 8'b10110100                        ? OP_CBZ  :
               w[31:21] == 11'b11010110000                    ? OP_BR   : OP_NOP;
    endfunction

    // ID keeps the full word for operand checks; later stages only need the class (NOP = invalid)
    logic [31:0] id_ir_q, id_ir_d;
    logic        id_v_q, id_v_d;
    op_e         ex_op_q, ex_op_d, mem_op_q, mem_op_d, wb_op_q, wb_op_d;
    logic [4:0]  ex_rt_q, ex_rt_d;
    logic [3:0]  nzvc_q, nzvc_d;

    op_e  id_op;
    logic ex_sets, rd_rn, rd_rm, rd_rt, load_use, flag_haz, hazard, lt, take;

    always_comb begin
        id_op    = id_v_q ? decode(id_ir_q) : OP_NOP;
        ex_sets  = ex_op_q inside {OP_ADDS, OP_SUBS};
        rd_rn    = id_op inside {OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR, OP_BR} && id_ir_q[9:5] == ex_rt_q;
        rd_rm    = id_op inside {OP_ADDS, OP_SUBS} && id_ir_q[20:16] == ex_rt_q;
        rd_rt    = id_op inside {OP_STUR, OP_CBZ} && id_ir_q[4:0] == ex_rt_q;
        load_use = LOAD_USE_DET && ex_op_q == OP_LDUR && ex_rt_q != 5'd31 && (rd_rn || rd_rm || rd_rt);
        flag_haz = !FLAG_FWD && id_op == OP_BLT && ex_sets;
        hazard   = load_use || flag_haz;
        lt       = (FLAG_FWD && ex_sets) ? bus.alu_n ^ bus.alu_v : nzvc_q[3] ^ nzvc_q[1];
        take     = !bus.stall_ext && !hazard &&
                   (id_op inside {OP_B, OP_BL} || (id_op == OP_CBZ && bus.cbz_zero) || (id_op == OP_BLT && lt));
    end

    always_comb begin
        id_ir_d  = id_ir_q;
        id_v_d   = id_v_q;
        ex_op_d  = ex_op_q;
        ex_rt_d  = ex_rt_q;
        mem_op_d = mem_op_q;
        wb_op_d  = wb_op_q;
        nzvc_d   = nzvc_q;
        if (!bus.stall_ext) begin
            wb_op_d  = mem_op_q;
            mem_op_d = ex_op_q;
            ex_op_d  = hazard ? OP_NOP : id_op;
            ex_rt_d  = id_ir_q[4:0];
            if (!hazard) begin
                id_ir_d = bus.instr;
                id_v_d  = bus.instr_valid && !(take && !DELAY_SLOT);
            end
            if (ex_sets) nzvc_d = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ir_q  <= '0;
            id_v_q   <= 1'b0;
            ex_op_q  <= OP_NOP;
            ex_rt_q  <= '0;
            mem_op_q <= OP_NOP;
            wb_op_q  <= OP_NOP;
            nzvc_q   <= '0;
        end else begin
            id_ir_q  <= id_ir_d;
            id_v_q   <= id_v_d;
            ex_op_q  <= ex_op_d;
            ex_rt_q  <= ex_rt_d;
            mem_op_q <= mem_op_d;
            wb_op_q  <= wb_op_d;
            nzvc_q   <= nzvc_d;
        end
    end

    assign bus.pc_hold       = bus.stall_ext || hazard;
    assign bus.take_branch   = take;
    assign bus.br_reg        = id_op == OP_BR;
    assign bus.id_reg2_rd    = id_op inside {OP_STUR, OP_CBZ};
    assign bus.ex_alu_src    = ex_op_q == OP_ADDI ? 2'b01 :
                               ex_op_q inside {OP_LDUR, OP_STUR} ? 2'b10 : 2'b00;
    assign bus.ex_alu_op     = ex_op_q == OP_SUBS ? 3'b011 :
                               ex_op_q inside {OP_ADDI, OP_ADDS, OP_LDUR, OP_STUR} ? 3'b010 : 3'b000;
    assign bus.ex_set_flags  = ex_sets;
    assign bus.mem_read      = mem_op_q == OP_LDUR;
    assign bus.mem_write     = mem_op_q == OP_STUR;
    assign bus.wb_reg_write  = wb_op_q inside {OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_BL};
    assign bus.wb_mem_to_reg = wb_op_q == OP_LDUR;
    assign bus.wb_link       = wb_op_q == OP_BL;
    assign bus.flag_n        = nzvc_q[3];
    assign bus.flag_z        = nzvc_q[2];
    assign bus.flag_v        = nzvc_q[1];
    assign bus.flag_c        = nzvc_q[0];
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed checks of two configurations (defaults, and FLAG_FWD=0/DELAY_SLOT=0)
module tb_pipe_ctrl_unit;
    localparam logic [31:0] LDUR1  = 32'hF8400041;
    localparam logic [31:0] LDUR31 = 32'hF840005F;
    localparam logic [31:0] ADDS1  = 32'hAB040023;
    localparam logic [31:0] ADDS31 = 32'hAB0403E3;
    localparam logic [31:0] SUBS   = 32'hEB0700C5;
    localparam logic [31:0] BLT    = 32'h5400004B;
    localparam logic [31:0] BR_    = 32'h14000004;
    localparam logic [31:0] BL     = 32'h94000004;
    localparam logic [31:0] ADDI   = 32'h91000549;
    localparam logic [31:0] STUR   = 32'hF8000041;
    localparam logic [31:0] CBZ    = 32'hB4000041;
    localparam logic [31:0] BRX30  = 32'hD61F03C0;

    logic clk, reset;
    logic [31:0] instr;
    logic instr_valid, stall_ext, alu_n, alu_z, alu_v, alu_c, cbz_zero;
    int n_cmp, n_bad;

    pipe_ctrl_if a_if ();
    pipe_ctrl_if b_if ();

    assign a_if.instr = instr;  assign a_if.instr_valid = instr_valid;  assign a_if.stall_ext = stall_ext;
    assign a_if.alu_n = alu_n;  assign a_if.alu_z = alu_z;  assign a_if.alu_v = alu_v;  assign a_if.alu_c = alu_c;
    assign a_if.cbz_zero = cbz_zero;
    assign b_if.instr = instr;  assign b_if.instr_valid = instr_valid;  assign b_if.stall_ext = stall_ext;
    assign b_if.alu_n = alu_n;  assign b_if.alu_z = alu_z;  assign b_if.alu_v = alu_v;  assign b_if.alu_c = alu_c;
    assign b_if.cbz_zero = cbz_zero;

    pipe_ctrl_unit dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    pipe_ctrl_unit #(.DELAY_SLOT(1'b0), .FLAG_FWD(1'b0), .LOAD_USE_DET(1'b1))
        dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    logic [18:0] a_out, b_out;
    logic [3:0]  a_flags, b_flags;
    assign a_flags = {a_if.flag_n, a_if.flag_z, a_if.flag_v, a_if.flag_c};
    assign b_flags = {b_if.flag_n, b_if.flag_z, b_if.flag_v, b_if.flag_c};
    assign a_out = {a_if.pc_hold, a_if.take_branch, a_if.br_reg, a_if.id_reg2_rd, a_if.ex_alu_src,
                    a_if.ex_alu_op, a_if.ex_set_flags, a_if.mem_read, a_if.mem_write, a_if.wb_reg_write,
                    a_if.wb_mem_to_reg, a_if.wb_link, a_flags};
    assign b_out = {b_if.pc_hold, b_if.take_branch, b_if.br_reg, b_if.id_reg2_rd, b_if.ex_alu_src,
                    b_if.ex_alu_op, b_if.ex_set_flags, b_if.mem_read, b_if.mem_write, b_if.wb_reg_write,
                    b_if.wb_mem_to_reg, b_if.wb_link, b_flags};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush;
        instr_valid = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        #1;
        n_cmp++; if (a_out !== 19'd0) begin n_bad++; $display("FAIL reset_a: got %h want 0", a_out); end
        n_cmp++; if (b_out !== 19'd0) begin n_bad++; $display("FAIL reset_b: got %h want 0", b_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use;
        instr = LDUR1; instr_valid = 1'b1;
        tick();
        instr = ADDS1; #1;
        n_cmp++; if (a_if.pc_hold !== 1'b0) begin n_bad++; $display("FAIL lu_c1_hold: got %b want 0", a_if.pc_hold); end
        tick();
        instr_valid = 1'b0; #1;
        n_cmp++; if (a_if.pc_hold !== 1'b1) begin n_bad++; $display("FAIL lu_c2_hold: got %b want 1", a_if.pc_hold); end
        n_cmp++; if (a_if.ex_alu_src !== 2'b10) begin n_bad++; $display("FAIL lu_c2_src: got %b want 10", a_if.ex_alu_src); end
        tick();
        n_cmp++; if (a_if.pc_hold !== 1'b0) begin n_bad++; $display("FAIL lu_c3_hold: got %b want 0", a_if.pc_hold); end
        n_cmp++; if (a_if.ex_set_flags !== 1'b0) begin n_bad++; $display("FAIL lu_c3_bubble: got %b want 0", a_if.ex_set_flags); end
        n_cmp++; if (a_if.mem_read !== 1'b1) begin n_bad++; $display("FAIL lu_c3_memrd: got %b want 1", a_if.mem_read); end
        tick();
        n_cmp++; if (a_if.ex_set_flags !== 1'b1) begin n_bad++; $display("FAIL lu_c4_sf: got %b want 1", a_if.ex_set_flags); end
        n_cmp++; if (a_if.ex_alu_op !== 3'b010) begin n_bad++; $display("FAIL lu_c4_op: got %b want 010", a_if.ex_alu_op); end
        flush();
        instr = LDUR31; instr_valid = 1'b1;
        tick();
        instr = ADDS31;
        tick();
        instr_valid = 1'b0; #1;
        n_cmp++; if (a_if.pc_hold !== 1'b0) begin n_bad++; $display("FAIL lu_x31_hold: got %b want 0", a_if.pc_hold); end
        flush();
    endtask

    task automatic test_flag_lt;
        instr = SUBS; instr_valid = 1'b1;
        tick();
        instr = BLT;
        tick();
        instr_valid = 1'b0; alu_n = 1'b1; alu_v = 1'b0; #1;
        n_cmp++; if (a_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL lt_fwd_take: got %b want 1", a_if.take_branch); end
        n_cmp++; if (a_if.pc_hold !== 1'b0) begin n_bad++; $display("FAIL lt_fwd_hold: got %b want 0", a_if.pc_hold); end
        n_cmp++; if (b_if.pc_hold !== 1'b1) begin n_bad++; $display("FAIL lt_nofwd_hold: got %b want 1", b_if.pc_hold); end
        n_cmp++; if (b_if.take_branch !== 1'b0) begin n_bad++; $display("FAIL lt_nofwd_take0: got %b want 0", b_if.take_branch); end
        tick();
        alu_n = 1'b0; #1;
        n_cmp++; if (b_if.pc_hold !== 1'b0) begin n_bad++; $display("FAIL lt_nofwd_hold2: got %b want 0", b_if.pc_hold); end
        n_cmp++; if (b_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL lt_nofwd_take1: got %b want 1", b_if.take_branch); end
        n_cmp++; if (b_if.ex_set_flags !== 1'b0) begin n_bad++; $display("FAIL lt_nofwd_bubble: got %b want 0", b_if.ex_set_flags); end
        n_cmp++; if (b_flags !== 4'b1000) begin n_bad++; $display("FAIL lt_flags_b: got %b want 1000", b_flags); end
        n_cmp++; if (a_flags !== 4'b1000) begin n_bad++; $display("FAIL lt_flags_a: got %b want 1000", a_flags); end
        flush();
    endtask

    task automatic test_branch_squash;
        instr = BR_; instr_valid = 1'b1;
        tick();
        instr = ADDI; #1;
        n_cmp++; if (a_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL b_take_a: got %b want 1", a_if.take_branch); end
        n_cmp++; if (b_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL b_take_b: got %b want 1", b_if.take_branch); end
        tick();
        instr_valid = 1'b0; #1;
        for (int c = 2; c <= 6; c++) begin
            n_cmp++; if (a_if.wb_reg_write !== (c == 5)) begin n_bad++; $display("FAIL ds1_wb_c%0d: got %b want %b", c, a_if.wb_reg_write, c == 5); end
            n_cmp++; if (b_if.wb_reg_write !== 1'b0) begin n_bad++; $display("FAIL ds0_wb_c%0d: got %b want 0", c, b_if.wb_reg_write); end
            if (c == 3) begin
                n_cmp++; if (a_if.ex_alu_src !== 2'b01) begin n_bad++; $display("FAIL ds1_src: got %b want 01", a_if.ex_alu_src); end
                n_cmp++; if (b_if.ex_alu_src !== 2'b00) begin n_bad++; $display("FAIL ds0_src: got %b want 00", b_if.ex_alu_src); end
            end
            tick();
        end
        flush();
    endtask

    task automatic test_stall_ext;
        instr = STUR; instr_valid = 1'b1;
        tick();
        instr = ADDS1; #1;
        n_cmp++; if (a_if.id_reg2_rd !== 1'b1) begin n_bad++; $display("FAIL st_reg2: got %b want 1", a_if.id_reg2_rd); end
        tick();
        instr_valid = 1'b0; #1;
        n_cmp++; if (a_if.ex_alu_src !== 2'b10) begin n_bad++; $display("FAIL st_src: got %b want 10", a_if.ex_alu_src); end
        tick();
        stall_ext = 1'b1; {alu_n, alu_z, alu_v, alu_c} = 4'b0111; #1;
        n_cmp++; if (a_if.mem_write !== 1'b1) begin n_bad++; $display("FAIL st_memwr_c3: got %b want 1", a_if.mem_write); end
        n_cmp++; if (a_if.pc_hold !== 1'b1) begin n_bad++; $display("FAIL st_hold_c3: got %b want 1", a_if.pc_hold); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) stall_ext = 1'b0;
            #1;
            n_cmp++; if (a_if.mem_write !== 1'b1) begin n_bad++; $display("FAIL st_memwr_k%0d: got %b want 1", k, a_if.mem_write); end
            n_cmp++; if (a_if.pc_hold !== (k < 2)) begin n_bad++; $display("FAIL st_hold_k%0d: got %b want %b", k, a_if.pc_hold, k < 2); end
            n_cmp++; if (a_flags !== 4'b1000) begin n_bad++; $display("FAIL st_flags_k%0d: got %b want 1000", k, a_flags); end
        end
        tick();
        n_cmp++; if (a_if.mem_write !== 1'b0) begin n_bad++; $display("FAIL st_memwr_end: got %b want 0", a_if.mem_write); end
        n_cmp++; if (a_flags !== 4'b0111) begin n_bad++; $display("FAIL st_flags_end: got %b want 0111", a_flags); end
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        flush();
    endtask

    task automatic test_reset_midflight;
        instr = BL; instr_valid = 1'b1;
        tick();
        instr = LDUR1; #1;
        n_cmp++; if (a_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL rm_bl_take: got %b want 1", a_if.take_branch); end
        tick();
        instr_valid = 1'b0;
        tick();
        n_cmp++; if (a_if.ex_alu_src !== 2'b10) begin n_bad++; $display("FAIL rm_ex_ldur: got %b want 10", a_if.ex_alu_src); end
        reset = 1'b1; stall_ext = 1'b1;
        tick();
        reset = 1'b0; stall_ext = 1'b0; #1;
        n_cmp++; if (a_out !== 19'd0) begin n_bad++; $display("FAIL rm_out_a: got %h want 0", a_out); end
        n_cmp++; if (b_out !== 19'd0) begin n_bad++; $display("FAIL rm_out_b: got %h want 0", b_out); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if ((a_if.wb_link | b_if.wb_link) !== 1'b0) begin n_bad++; $display("FAIL rm_link_c%0d: got %b%b want 00", c, a_if.wb_link, b_if.wb_link); end
        end
    endtask

    task automatic test_cbz_br;
        instr = CBZ; instr_valid = 1'b1;
        tick();
        instr = BRX30; cbz_zero = 1'b0; #1;
        n_cmp++; if (a_if.id_reg2_rd !== 1'b1) begin n_bad++; $display("FAIL cbz_reg2: got %b want 1", a_if.id_reg2_rd); end
        n_cmp++; if (a_if.take_branch !== 1'b0) begin n_bad++; $display("FAIL cbz_nz_take: got %b want 0", a_if.take_branch); end
        cbz_zero = 1'b1; #1;
        n_cmp++; if (a_if.take_branch !== 1'b1) begin n_bad++; $display("FAIL cbz_z_take: got %b want 1", a_if.take_branch); end
        tick();
        instr_valid = 1'b0; cbz_zero = 1'b0; #1;
        n_cmp++; if (a_if.br_reg !== 1'b1) begin n_bad++; $display("FAIL br_reg: got %b want 1", a_if.br_reg); end
        n_cmp++; if (a_if.take_branch !== 1'b0) begin n_bad++; $display("FAIL br_take: got %b want 0", a_if.take_branch); end
        n_cmp++; if (b_if.br_reg !== 1'b0) begin n_bad++; $display("FAIL br_squashed_b: got %b want 0", b_if.br_reg); end
        flush();
    endtask

    task automatic test_unknown;
        instr = 32'hFFFFFFFF; instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (a_out !== 19'd0) begin n_bad++; $display("FAIL unk_a_c%0d: got %h want 0", c, a_out); end
            n_cmp++; if (b_out !== 19'd0) begin n_bad++; $display("FAIL unk_b_c%0d: got %h want 0", c, b_out); end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        instr = '0; instr_valid = 1'b0; stall_ext = 1'b0; cbz_zero = 1'b0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
        test_reset();
        test_load_use();
        test_flag_lt();
        test_branch_squash();
        test_stall_ext();
        test_reset_midflight();
        test_cbz_br();
        test_unknown();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
